cbus_rr_arbiter: RTL

//  N-port CBus arbiter between the bus converters/caches and the single memory-side CBus.

---
 rtl/cbus_rr_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cbus_rr_arbiter.sv
`default_nettype none

// ============================================================================
//  Package      : cbus_pkg
//  Description  : CBus request/response structures shared by the arbiter and
//                 anything that connects to it.
//  Revision     : 1.0 - initial release
// ============================================================================
package cbus_pkg;

    // Request channel from a master (bus converter / cache) toward memory.
    typedef struct packed {
        logic        valid;     // request present; held until the last beat
        logic        is_write;  // 1: write, 0: read
        logic [31:0] addr;      // start address of the transaction
        logic [2:0]  size;      // log2 of bytes per beat
        logic [7:0]  len;       // beats minus one (0 = single beat)
        logic [31:0] data;      // write data for the current beat
        logic [3:0]  strobe;    // byte enables for the current beat
    } cbus_req_t;

    // Response channel from memory back to a master.
    typedef struct packed {
        logic        ready;     // beat accepted / read data valid
        logic        last;      // final beat of the transaction
        logic [31:0] data;      // read data for the current beat
    } cbus_resp_t;

endpackage : cbus_pkg

// ============================================================================
//  Module       : cbus_rr_arbiter
//  Description  : N-port CBus arbiter. Grants one upstream port at a time and
//                 keeps the grant for the whole burst, up to and including the
//                 response beat flagged ready&&last. Arbitration is either
//                 round-robin (pointer rotates after each completed
//                 transaction) or fixed priority (port 0 highest). Responses
//                 are routed only to the granted port.
//  Ports        :
//    clk        in   core clock
//    reset      in   asynchronous, active-high reset
//    ireqs      in   NUM_PORTS requests from upstream ports
//    iresps     out  NUM_PORTS responses to upstream ports
//    oreq       out  request to the memory-side CBus
//    oresp      in   response from the memory-side CBus
//    grant_idx  out  index of the granted port (meaningful while busy=1)
//    busy       out  1 while a transaction owns the bus
//  Revision     : 1.0 - initial release
// ============================================================================
module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int RR_MODE   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  cbus_req_t                    ireqs  [NUM_PORTS],
    output cbus_resp_t                   iresps [NUM_PORTS],
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_rr_ptr;     // first port considered in the next IDLE

    logic             w_busy;
    logic             w_any;
    logic [IDX_W-1:0] w_pick;
    logic             w_done;
    logic [IDX_W-1:0] w_next_ptr;
    cbus_req_t        w_sel_req;

    assign w_busy = (r_state == ST_BUSY);

    // ------------------------------------------------------------------------
    // Arbitration (evaluated only in IDLE).
    // Offsets from the base are scanned from the farthest to the nearest so
    // that the last hit - the nearest valid port at or after the base - wins.
    // Fixed priority is the same search with the base pinned to 0, which
    // yields the lowest valid index. The inner loop uses constant indices so
    // the port array is never addressed by a wide runtime value.
    // ------------------------------------------------------------------------
    always_comb begin
        int unsigned base;
        int unsigned cand;
        w_any  = 1'b0;
        w_pick = '0;
        base   = 0;
        cand   = 0;
        if (RR_MODE != 0) begin
            base = int'(r_rr_ptr);
        end
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = base + unsigned'(k);
            if (cand >= unsigned'(NUM_PORTS)) begin
                cand = cand - unsigned'(NUM_PORTS);
            end
            for (int j = 0; j < NUM_PORTS; j++) begin
                if ((cand == unsigned'(j)) && ireqs[j].valid) begin
                    w_any  = 1'b1;
                    w_pick = IDX_W'(j);
                end
            end
        end
    end

    // A transaction ends on the beat that is both accepted and last; other
    // requesters never influence the grant before that point.
    assign w_done = w_busy && oresp.ready && oresp.last;

    // Pointer moves to the port after the one just served, wrapping at the
    // top so that non-power-of-two port counts rotate correctly.
    assign w_next_ptr = (r_grant_idx == IDX_W'(NUM_PORTS - 1))
                        ? '0
                        : r_grant_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_idx <= w_pick;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A master dropping valid mid-burst is a protocol error;
                    // the grant is deliberately kept until the last beat.
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        if (RR_MODE != 0) begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Request path: combinational pass-through of the granted port while
    // BUSY, all zero otherwise. Since the state clears asynchronously, reset
    // silences the memory side in the same cycle it is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel_req = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (r_grant_idx == IDX_W'(j)) begin
                w_sel_req = ireqs[j];
            end
        end
    end

    assign oreq = w_busy ? w_sel_req : '0;

    // ------------------------------------------------------------------------
    // Response path: only the granted port sees the memory response.
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_resp_route
        assign iresps[j] = (w_busy && (r_grant_idx == IDX_W'(j))) ? oresp : '0;
    end

    assign grant_idx = r_grant_idx;
    assign busy      = w_busy;

endmodule : cbus_rr_arbiter

`default_nettype wire
